// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a stream of bytes into full-width words. It has one
// accumulator and one output holding register, so the input side and the
// output side advance independently. A flush request emits a partial word.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   in_data      input byte
//   in_valid     in_data is valid
//   in_ready     a byte is accepted this cycle when in_valid & in_ready
//                (combinational)
//   flush        request to emit the current partial word (a pulse is enough)
//   out_data     packed word
//   out_valid    out_data, out_partial and out_count are valid
//   out_ready    the consumer takes the word this cycle
//   out_partial  the word was emitted by a flush and holds fewer than
//                bytes_per_word bytes
//   out_count    number of bytes in the word
module byte_word_packer #(
    parameter  int unsigned byte_width     = 8,
    parameter  int unsigned bytes_per_word = 4,
    parameter  int unsigned MSB_FIRST      = 0,
    localparam int unsigned WW             = byte_width * bytes_per_word,
    localparam int unsigned CW             = $clog2(bytes_per_word + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [byte_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_partial,
    output logic [CW-1:0]         out_count
);

    localparam logic [CW-1:0] LAST_CNT = CW'(bytes_per_word - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(bytes_per_word);

    logic [WW-1:0] accumulator;
    logic [WW-1:0] acc_next;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] cnt_next;
    logic          flush_pend;
    logic          flush_req;
    logic          out_free;
    logic          accept;
    logic          word_full;
    logic          flush_serve;
    logic          flush_drop;

    // Handshake, next accumulator contents and word-emission decisions
    always_comb begin
        out_free  = !out_valid || out_ready;
        in_ready  = (byte_cnt != LAST_CNT) || out_free;
        accept    = in_valid && in_ready;
        word_full = accept && (byte_cnt == LAST_CNT);
        cnt_next  = byte_cnt + CW'(accept);
        flush_req = flush_pend || flush;

        // Byte k goes to slot k, or to the mirrored slot when MSB_FIRST is set
        acc_next = accumulator;
        for (int unsigned k = 0; k < bytes_per_word; k++) begin
            if (accept && (byte_cnt == CW'(k))) begin
                if (MSB_FIRST != 0) begin
                    acc_next[(bytes_per_word - 1 - k) * byte_width +: byte_width] = in_data;
                end else begin
                    acc_next[k * byte_width +: byte_width] = in_data;
                end
            end
        end

        // A completed word takes priority over a flush, so no empty word follows it
        flush_serve = flush_req && out_free && (cnt_next != '0) && !word_full;
        // Nothing is held, so a flush request is simply dropped
        flush_drop  = flush_req && (cnt_next == '0);
    end

    // Accumulator, byte counter, sticky flush and output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accumulator <= '0;
            byte_cnt    <= '0;
            flush_pend  <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
            out_count   <= '0;
        end else begin
            if (word_full || flush_serve || flush_drop) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end

            if (word_full || flush_serve) begin
                out_data    <= acc_next;
                out_valid   <= 1'b1;
                out_partial <= !word_full;
                out_count   <= word_full ? FULL_CNT : cnt_next;
                accumulator <= '0;
                byte_cnt    <= '0;
            end else begin
                accumulator <= acc_next;
                byte_cnt    <= cnt_next;
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_word_packer.sv
// Testbench for byte_word_packer. Two instances, one LSB-first and one
// MSB-first, share all inputs. A queue-based reference model predicts the
// outputs, and the bench compares against it every cycle. Words taken by the
// consumer are logged and then checked against hand-computed literals.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_ready_l, in_ready_m;
    logic [31:0] out_data_l, out_data_m;
    logic        out_valid_l, out_valid_m;
    logic        out_partial_l, out_partial_m;
    logic [2:0]  out_count_l, out_count_m;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mq[$];       // bytes collected toward the next word
    logic [7:0] hb[$];       // bytes in the word currently offered
    bit         hv, hp, fp;  // word offered, word partial, flush pending

    // Words taken by the consumer, as seen on the LSB-first instance
    logic [31:0] log_w[$];
    bit          log_p[$];
    int          log_c[$];

    always #5 clk = ~clk;

    byte_word_packer #(.byte_width(8), .bytes_per_word(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .flush(flush), .out_data(out_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_partial(out_partial_l), .out_count(out_count_l));

    byte_word_packer #(.byte_width(8), .bytes_per_word(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .out_partial(out_partial_m), .out_count(out_count_m));

    function automatic logic [31:0] pack(input logic [7:0] b[$], input bit msb);
        logic [31:0] w = '0;
        for (int k = 0; k < b.size(); k++) begin
            int s = msb ? 3 - k : k;
            w[s*8 +: 8] = b[k];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every cycle the word on offer is taken, bytes are collected, and
    // a word is emitted when four bytes are in or when a flush can be served
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete(); hb.delete();
            hv = 0; hp = 0; fp = 0;
        end else begin
            bit free, rdy, freq;
            free = !hv || out_ready;
            rdy  = (mq.size() != 3) || free;
            freq = fp || flush;
            if (hv && out_ready) hv = 0;
            if (in_valid && rdy) mq.push_back(in_data);
            if (mq.size() == 4) begin
                hb = mq; mq.delete(); hv = 1; hp = 0; fp = 0;
            end else if (freq && free && mq.size() > 0) begin
                hb = mq; mq.delete(); hv = 1; hp = 1; fp = 0;
            end else if (freq && mq.size() == 0) begin
                fp = 0;
            end else if (flush) begin
                fp = 1;
            end
        end
    end

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        if (!rst) begin
            bit exp_rdy;
            exp_rdy = (mq.size() != 3) || !hv || out_ready;
            chk("in_ready_l", 32'(in_ready_l), 32'(exp_rdy));
            chk("in_ready_m", 32'(in_ready_m), 32'(exp_rdy));
            chk("out_valid_l", 32'(out_valid_l), 32'(hv));
            chk("out_valid_m", 32'(out_valid_m), 32'(hv));
            if (hv) begin
                chk("out_data_l", out_data_l, pack(hb, 0));
                chk("out_data_m", out_data_m, pack(hb, 1));
                chk("out_partial_l", 32'(out_partial_l), 32'(hp));
                chk("out_partial_m", 32'(out_partial_m), 32'(hp));
                chk("out_count_l", 32'(out_count_l), 32'(hb.size()));
                chk("out_count_m", 32'(out_count_m), 32'(hb.size()));
            end
            if (out_valid_l && out_ready) begin
                log_w.push_back(out_data_l);
                log_p.push_back(out_partial_l);
                log_c.push_back(int'(out_count_l));
            end
        end
    end

    // Offer one byte and hold it until it is accepted
    task automatic send(input logic [7:0] b);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 50 && !done; n++) begin
            bit r;
            @(negedge clk);
            r = in_ready_l;
            @(posedge clk);
            #1;
            done = r;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_log(input int idx, input logic [31:0] w, input bit p, input int c);
        if (log_w.size() <= idx) begin
            checks++; failures++;
            $display("FAIL log_missing: entry %0d absent, size %0d", idx, log_w.size());
        end else begin
            chk("log_word", log_w[idx], w);
            chk("log_partial", 32'(log_p[idx]), 32'(p));
            chk("log_count", 32'(log_c[idx]), 32'(c));
        end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_l), 32'd0);
        chk("rst_out_data", out_data_l, 32'd0);
        chk("rst_out_partial", 32'(out_partial_l), 32'd0);
        chk("rst_out_count", 32'(out_count_l), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_l), 32'd1);
        @(posedge clk); #1;

        // Four bytes back to back give one full word on the next cycle
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(out_valid_l), 32'd1);
        chk("t1_word_lsb", out_data_l, 32'h44332211);
        chk("t1_word_msb", out_data_m, 32'h11223344);
        chk("t1_count", 32'(out_count_l), 32'd4);
        chk("t1_partial", 32'(out_partial_l), 32'd0);
        idle(3);
        expect_log(0, 32'h44332211, 0, 4);

        // Back-pressure: the first word is held and the eighth byte stalls
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(8'(i));
        in_data = 8'h08; in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t3_stalled", 32'(in_ready_l), 32'd0);
        chk("t3_held", out_data_l, 32'h04030201);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h08);
        idle(4);
        expect_log(1, 32'h04030201, 0, 4);
        expect_log(2, 32'h08070605, 0, 4);
        chk("t3_log_size", 32'(log_w.size()), 32'd3);

        // A flush after two bytes emits a partial word; the next bytes start at slot 0
        send(8'hAA); send(8'hBB);
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t4_word_lsb", out_data_l, 32'h0000BBAA);
        chk("t4_word_msb", out_data_m, 32'hAABB0000);
        chk("t4_partial", 32'(out_partial_l), 32'd1);
        chk("t4_count", 32'(out_count_l), 32'd2);
        @(posedge clk); #1;
        send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
        idle(3);
        expect_log(3, 32'h0000BBAA, 1, 2);
        expect_log(4, 32'hFFEEDDCC, 0, 4);

        // A flush with nothing collected emits no word
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(3);
        @(negedge clk);
        chk("t5_empty_flush", 32'(out_valid_l), 32'd0);
        chk("t5_log_size_a", 32'(log_w.size()), 32'd5);
        @(posedge clk); #1;
        // A flush on the cycle of the fourth byte gives one full word only
        send(8'h31); send(8'h32); send(8'h33);
        flush = 1'b1;
        send(8'h34);
        flush = 1'b0;
        idle(4);
        expect_log(5, 32'h34333231, 0, 4);
        chk("t5_log_size_b", 32'(log_w.size()), 32'd6);

        // Reset while a word is held and two more bytes are collected
        out_ready = 1'b0;
        send(8'h41); send(8'h42); send(8'h43); send(8'h44);
        send(8'h45); send(8'h46);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid_l), 32'd0);
        chk("t6_data", out_data_l, 32'd0);
        chk("t6_partial", 32'(out_partial_m), 32'd0);
        chk("t6_count", 32'(out_count_m), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 32'(in_ready_l), 32'd1);
        @(posedge clk); #1;
        send(8'h51); send(8'h52); send(8'h53); send(8'h54);
        idle(3);
        expect_log(6, 32'h54535251, 0, 4);
        chk("t6_log_size", 32'(log_w.size()), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
